// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, 1-cycle imem request/response, DEPTH-entry
// instruction FIFO to decode. Optional perf counters under `IF_PERF_CNT_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pcplus4,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed,
`endif
    input  logic        id_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetch_pc, req_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   pc_mem  [DEPTH];
    logic [31:0]   ins_mem [DEPTH];

    logic [CW:0]   occ;
    logic          empty, resp, head_vld, pop, bypass, wr, rd;
    logic [31:0]   head_pc, head_ins;
    logic          unused_redir_lsb;

    assign unused_redir_lsb = ^redir_pc[1:0];

    // Credit check: outstanding response plus stored entries must fit the FIFO.
    assign occ       = (CW+1)'(count) + (CW+1)'(inflight);
    assign empty     = (count == '0);
    assign imem_req  = !rst && !redir_valid && (occ < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc;

    // A response arriving into an empty FIFO is presented to decode the same
    // cycle; if decode takes it, it never gets written.
    assign resp     = !rst && !redir_valid && inflight;
    assign head_vld = !rst && !redir_valid && (!empty || inflight);
    assign head_pc  = empty ? req_pc : pc_mem[rd_ptr];
    assign head_ins = empty ? imem_rdata : ins_mem[rd_ptr];
    assign pop      = head_vld && id_ready;
    assign bypass   = pop && empty;
    assign wr       = resp && !bypass;
    assign rd       = pop && !empty;

    assign if_valid   = head_vld;
    assign if_pc      = head_vld ? head_pc  : 32'h0;
    assign if_instr   = head_vld ? head_ins : 32'h0;
    assign if_pcplus4 = if_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= 32'h0;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redir_valid) begin
            fetch_pc <= {redir_pc[31:2], 2'b00};
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (imem_req) begin
                fetch_pc <= fetch_pc + 32'd4;
                req_pc   <= fetch_pc;
            end
            inflight <= imem_req;
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            case ({wr, rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            pc_mem[wr_ptr]  <= req_pc;
            ins_mem[wr_ptr] <= imem_rdata;
        end
    end

`ifdef IF_PERF_CNT_EN
    // Fetched counts every accepted response, including ones handed straight to decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= 32'h0;
            perf_flushed <= 32'h0;
        end else begin
            if (resp)        perf_fetched <= perf_fetched + 32'd1;
            if (redir_valid) perf_flushed <= perf_flushed + 32'(occ);
        end
    end
`endif
endmodule
